renkon_sched: RTL and testbench

RENKON_SCHED -- requirements
Module: renkon_sched

---
 rtl/renkon_sched.sv | 231 +++++++++++++++++++++++
 tb/tb_renkon_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/renkon_sched.sv
// Convolution scheduler: loads per-core weights, then streams raster pixel addresses per input channel.
// Define RENKON_BIAS_EN to add a per-group bias-load phase (b_we/b_addr ports, S_BIAS state).
module renkon_sched #(
    parameter  int CORE   = 8,
    parameter  int CHW    = 10,
    parameter  int ISW    = 6,
    parameter  int IADDRW = 16,
    parameter  int WADDRW = 16,
    parameter  int OADDRW = 16,
    localparam int FSW    = 4,
    localparam int CW     = $clog2(CORE)
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              req,
    input  logic [CHW-1:0]    total_out,
    input  logic [CHW-1:0]    total_in,
    input  logic [ISW-1:0]    img_size,
    input  logic [FSW-1:0]    fil_size,
    output logic              ack,
    output logic              err,
    output logic [CW:0]       out_nch,
    output logic              w_we,
    output logic [CW-1:0]     w_core,
    output logic [WADDRW-1:0] w_addr,
    output logic              conv_en,
    output logic [IADDRW-1:0] in_addr,
    output logic              acc_clr,
    output logic              win_valid,
    output logic              out_we,
    output logic [OADDRW-1:0] out_addr
`ifdef RENKON_BIAS_EN
    ,
    output logic              b_we,
    output logic [WADDRW-1:0] b_addr
`endif
);

    typedef enum logic [2:0] {
        S_WAIT,
`ifdef RENKON_BIAS_EN
        S_BIAS,
`endif
        S_WEIGHT,
        S_CONV,
        S_NEXT
    } state_t;

    state_t         state_reg;
    logic [CHW-1:0] tin_reg;
    logic [CHW-1:0] grp_rem_reg;
    logic [CHW-1:0] ch_reg;
    logic [ISW-1:0] isz_reg;
    logic [ISW-1:0] fm1_reg;
    logic [7:0]     fsq_reg;
    logic [7:0]     k_reg;
    logic [ISW-1:0] row_reg;
    logic [ISW-1:0] col_reg;

    logic [ISW+FSW-1:0] fil_ext, img_ext;
    logic               bad_cfg;
    logic [CW:0]        core_inc;
    logic               last_k, last_core, col_last, row_last, last_ch, last_grp, win_nxt;
    logic [ISW-1:0]     col_next, row_next;
    logic [CHW-1:0]     rem_next;

    // Active cores in a group: the remaining output channels, capped at CORE.
    function automatic logic [CW:0] grp_n(input logic [CHW-1:0] rem);
        return (rem >= CHW'(CORE)) ? (CW+1)'(CORE) : rem[CW:0];
    endfunction

    assign fil_ext   = {{ISW{1'b0}}, fil_size};
    assign img_ext   = {{FSW{1'b0}}, img_size};
    assign bad_cfg   = (total_out == '0) || (total_in == '0) || (fil_size == '0) || (fil_ext > img_ext);
    assign core_inc  = {1'b0, w_core} + (CW+1)'(1);
    assign last_k    = (k_reg == fsq_reg - 8'd1);
    assign last_core = (w_core == CW'(CORE - 1));
    assign col_last  = (col_reg == isz_reg - ISW'(1));
    assign row_last  = (row_reg == isz_reg - ISW'(1));
    assign col_next  = col_last ? '0 : col_reg + ISW'(1);
    assign row_next  = col_last ? row_reg + ISW'(1) : row_reg;
    assign win_nxt   = (row_next >= fm1_reg) && (col_next >= fm1_reg);
    assign last_ch   = (ch_reg == tin_reg - CHW'(1));
    assign last_grp  = (grp_rem_reg <= CHW'(CORE));
    assign rem_next  = grp_rem_reg - CHW'(CORE);

    always_ff @(posedge clk) begin
        if (!xrst) begin
            state_reg   <= S_WAIT;
            ack         <= 1'b1;
            err         <= 1'b0;
            out_nch     <= '0;
            w_we        <= 1'b0;
            w_core      <= '0;
            w_addr      <= '0;
            conv_en     <= 1'b0;
            in_addr     <= '0;
            acc_clr     <= 1'b0;
            win_valid   <= 1'b0;
            out_we      <= 1'b0;
            out_addr    <= '0;
            tin_reg     <= '0;
            grp_rem_reg <= '0;
            ch_reg      <= '0;
            isz_reg     <= '0;
            fm1_reg     <= '0;
            fsq_reg     <= '0;
            k_reg       <= '0;
            row_reg     <= '0;
            col_reg     <= '0;
`ifdef RENKON_BIAS_EN
            b_we        <= 1'b0;
            b_addr      <= '0;
`endif
        end else begin
            err <= 1'b0;
            case (state_reg)
                S_WAIT: begin
                    if (req) begin
                        if (bad_cfg) begin
                            err <= 1'b1;
                        end else begin
                            tin_reg     <= total_in;
                            isz_reg     <= img_size;
                            fm1_reg     <= ISW'(fil_size) - ISW'(1);
                            fsq_reg     <= 8'(fil_size) * 8'(fil_size);
                            grp_rem_reg <= total_out;
                            out_nch     <= grp_n(total_out);
                            ch_reg      <= '0;
                            ack         <= 1'b0;
                            w_addr      <= '0;
                            in_addr     <= '0;
                            out_addr    <= '0;
                            w_core      <= '0;
                            k_reg       <= '0;
`ifdef RENKON_BIAS_EN
                            b_addr      <= '0;
                            b_we        <= 1'b1;
                            state_reg   <= S_BIAS;
`else
                            w_we        <= 1'b1;
                            state_reg   <= S_WEIGHT;
`endif
                        end
                    end
                end
`ifdef RENKON_BIAS_EN
                S_BIAS: begin
                    b_addr <= b_addr + WADDRW'(b_we);
                    if (last_core) begin
                        b_we      <= 1'b0;
                        w_core    <= '0;
                        w_we      <= 1'b1;
                        state_reg <= S_WEIGHT;
                    end else begin
                        w_core <= core_inc[CW-1:0];
                        b_we   <= (core_inc < out_nch);
                    end
                end
`endif
                S_WEIGHT: begin
                    w_addr <= w_addr + WADDRW'(w_we);
                    if (last_k) begin
                        k_reg <= '0;
                        if (last_core) begin
                            w_core    <= '0;
                            w_we      <= 1'b0;
                            conv_en   <= 1'b1;
                            row_reg   <= '0;
                            col_reg   <= '0;
                            acc_clr   <= (ch_reg == '0);
                            win_valid <= (fm1_reg == '0);
                            out_we    <= (fm1_reg == '0) && last_ch;
                            state_reg <= S_CONV;
                        end else begin
                            w_core <= core_inc[CW-1:0];
                            w_we   <= (core_inc < out_nch);
                        end
                    end else begin
                        k_reg <= k_reg + 8'd1;
                    end
                end
                S_CONV: begin
                    in_addr  <= in_addr + IADDRW'(1);
                    out_addr <= out_addr + OADDRW'(out_we);
                    col_reg  <= col_next;
                    row_reg  <= row_next;
                    if (col_last && row_last) begin
                        conv_en   <= 1'b0;
                        acc_clr   <= 1'b0;
                        win_valid <= 1'b0;
                        out_we    <= 1'b0;
                        row_reg   <= '0;
                        col_reg   <= '0;
                        state_reg <= S_NEXT;
                    end else begin
                        win_valid <= win_nxt;
                        out_we    <= win_nxt && last_ch;
                    end
                end
                S_NEXT: begin
                    w_core <= '0;
                    k_reg  <= '0;
                    if (!last_ch) begin
                        ch_reg    <= ch_reg + CHW'(1);
                        w_we      <= 1'b1;
                        state_reg <= S_WEIGHT;
                    end else if (last_grp) begin
                        ack       <= 1'b1;
                        state_reg <= S_WAIT;
                    end else begin
                        // New group: input image is re-read from the start.
                        grp_rem_reg <= rem_next;
                        out_nch     <= grp_n(rem_next);
                        ch_reg      <= '0;
                        in_addr     <= '0;
`ifdef RENKON_BIAS_EN
                        b_we        <= 1'b1;
                        state_reg   <= S_BIAS;
`else
                        w_we        <= 1'b1;
                        state_reg   <= S_WEIGHT;
`endif
                    end
                end
                default: state_reg <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_renkon_sched.sv
// Directed self-checking bench for renkon_sched; bias checks compile only with RENKON_BIAS_EN.
module tb_renkon_sched;
    localparam int CORE = 8, CHW = 10, ISW = 6, FSW = 4, CW = 3;
    localparam int IADDRW = 16, WADDRW = 16, OADDRW = 16;

    logic              clk = 1'b0;
    logic              xrst = 1'b0;
    logic              req = 1'b0;
    logic [CHW-1:0]    total_out = '0;
    logic [CHW-1:0]    total_in = '0;
    logic [ISW-1:0]    img_size = '0;
    logic [FSW-1:0]    fil_size = '0;
    logic              ack, err, w_we, conv_en, acc_clr, win_valid, out_we;
    logic [CW:0]       out_nch;
    logic [CW-1:0]     w_core;
    logic [WADDRW-1:0] w_addr;
    logic [IADDRW-1:0] in_addr;
    logic [OADDRW-1:0] out_addr;
`ifdef RENKON_BIAS_EN
    logic              b_we;
    logic [WADDRW-1:0] b_addr;
`endif

    renkon_sched #(.CORE(CORE), .CHW(CHW), .ISW(ISW), .IADDRW(IADDRW), .WADDRW(WADDRW), .OADDRW(OADDRW)) dut (
        .clk(clk), .xrst(xrst), .req(req), .total_out(total_out), .total_in(total_in),
        .img_size(img_size), .fil_size(fil_size), .ack(ack), .err(err), .out_nch(out_nch),
        .w_we(w_we), .w_core(w_core), .w_addr(w_addr), .conv_en(conv_en), .in_addr(in_addr),
        .acc_clr(acc_clr), .win_valid(win_valid), .out_we(out_we), .out_addr(out_addr)
`ifdef RENKON_BIAS_EN
        , .b_we(b_we), .b_addr(b_addr)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Event counters sampled on the falling edge.
    int n_wwe, n_conv, n_owe, n_err, n_accclr, n_win, n_bwe, n_acklow, nch_cnt;
    logic [CW:0] nch_seq [4];
    logic [CW:0] last_nch;
    int first_w, first_in, first_out;

    task automatic clear_mon();
        n_wwe = 0; n_conv = 0; n_owe = 0; n_err = 0; n_accclr = 0; n_win = 0; n_bwe = 0;
        n_acklow = 0; nch_cnt = 0; last_nch = '0;
        first_w = -1; first_in = -1; first_out = -1;
    endtask

    always @(negedge clk) begin
        if (w_we === 1'b1) begin
            if (first_w < 0) first_w = int'(w_addr);
            n_wwe++;
        end
        if (conv_en === 1'b1) begin
            if (first_in < 0) first_in = int'(in_addr);
            n_conv++;
        end
        if (out_we === 1'b1) begin
            if (first_out < 0) first_out = int'(out_addr);
            n_owe++;
        end
        if (err === 1'b1) n_err++;
        if (acc_clr === 1'b1) n_accclr++;
        if (win_valid === 1'b1) n_win++;
        if (ack !== 1'b1) n_acklow++;
`ifdef RENKON_BIAS_EN
        if (b_we === 1'b1) n_bwe++;
`endif
        if (ack === 1'b0 && out_nch !== last_nch) begin
            if (nch_cnt < 4) nch_seq[nch_cnt] = out_nch;
            nch_cnt++;
            last_nch = out_nch;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        xrst = 1'b0;
        req  = 1'b0;
        repeat (2) @(negedge clk);
        xrst = 1'b1;
    endtask

    task automatic start_run(input int to, input int ti, input int img, input int fil);
        @(negedge clk);
        total_out = CHW'(to);
        total_in  = CHW'(ti);
        img_size  = ISW'(img);
        fil_size  = FSW'(fil);
        req = 1'b1;
        clear_mon();
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int cyc = 0;
        while (ack !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL idle_timeout: ack=%b after %0d cycles, need 1", ack, cyc); end
    endtask

    task automatic wait_conv(input int budget);
        int cyc = 0;
        while (conv_en !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (conv_en !== 1'b1) begin errors++; $display("FAIL conv_timeout: conv_en=%b after %0d cycles, need 1", conv_en, cyc); end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rst_ack: got %b need 1", ack); end
        checks++; if ({err, out_nch, w_we, w_core, conv_en, acc_clr, win_valid, out_we} !== '0) begin
            errors++; $display("FAIL rst_ctrl: err=%b nch=%0d w_we=%b core=%0d conv=%b clr=%b win=%b owe=%b need all 0",
                               err, out_nch, w_we, w_core, conv_en, acc_clr, win_valid, out_we); end
        checks++; if ({w_addr, in_addr, out_addr} !== '0) begin
            errors++; $display("FAIL rst_addr: w=%0d in=%0d out=%0d need 0", w_addr, in_addr, out_addr); end
        @(negedge clk);
        checks++; if (ack !== 1'b1 || conv_en !== 1'b0) begin errors++; $display("FAIL rst_hold: ack=%b conv=%b need 1/0", ack, conv_en); end
    endtask

    task automatic test_single_group();
        start_run(8, 1, 12, 5);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL single_ack_drop: got %b need 0", ack); end
        wait_idle(2000);
        checks++; if (n_wwe != 200) begin errors++; $display("FAIL single_wwe: got %0d need 200", n_wwe); end
        checks++; if (n_conv != 144) begin errors++; $display("FAIL single_conv: got %0d need 144", n_conv); end
        checks++; if (n_owe != 64) begin errors++; $display("FAIL single_owe: got %0d need 64", n_owe); end
        checks++; if (out_addr !== 16'd64) begin errors++; $display("FAIL single_oaddr: got %0d need 64", out_addr); end
        checks++; if (w_addr !== 16'd200) begin errors++; $display("FAIL single_waddr: got %0d need 200", w_addr); end
        checks++; if (in_addr !== 16'd144) begin errors++; $display("FAIL single_inaddr: got %0d need 144", in_addr); end
        checks++; if (n_accclr != 144) begin errors++; $display("FAIL single_accclr: got %0d need 144", n_accclr); end
        checks++; if (n_win != 64) begin errors++; $display("FAIL single_win: got %0d need 64", n_win); end
        checks++; if (nch_cnt != 1 || nch_seq[0] !== 4'd8) begin errors++; $display("FAIL single_nch: changes=%0d first=%0d need 1/8", nch_cnt, nch_seq[0]); end
    endtask

    task automatic test_two_groups();
        start_run(10, 2, 8, 3);
        wait_idle(3000);
        checks++; if (n_wwe != 180) begin errors++; $display("FAIL grp_wwe: got %0d need 180", n_wwe); end
        checks++; if (n_owe != 72) begin errors++; $display("FAIL grp_owe: got %0d need 72", n_owe); end
        checks++; if (n_conv != 256) begin errors++; $display("FAIL grp_conv: got %0d need 256", n_conv); end
        checks++; if (n_accclr != 128) begin errors++; $display("FAIL grp_accclr: got %0d need 128", n_accclr); end
        checks++; if (n_win != 144) begin errors++; $display("FAIL grp_win: got %0d need 144", n_win); end
        checks++; if (nch_cnt != 2 || nch_seq[0] !== 4'd8 || nch_seq[1] !== 4'd2) begin
            errors++; $display("FAIL grp_nch: changes=%0d seq=%0d,%0d need 2: 8,2", nch_cnt, nch_seq[0], nch_seq[1]); end
        checks++; if (in_addr !== 16'd128) begin errors++; $display("FAIL grp_inaddr: got %0d need 128", in_addr); end
        checks++; if (out_addr !== 16'd72) begin errors++; $display("FAIL grp_oaddr: got %0d need 72", out_addr); end
        checks++; if (w_addr !== 16'd180) begin errors++; $display("FAIL grp_waddr: got %0d need 180", w_addr); end
    endtask

    task automatic test_bad_cfg();
        start_run(8, 1, 12, 13);
        checks++; if (err !== 1'b1 || ack !== 1'b1) begin errors++; $display("FAIL bad_err_pulse: err=%b ack=%b need 1/1", err, ack); end
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL bad_err_width: err=%b need 0", err); end
        repeat (6) @(negedge clk);
        checks++; if (n_err != 1 || n_acklow != 0) begin errors++; $display("FAIL bad_ack: err_cycles=%0d ack_low=%0d need 1/0", n_err, n_acklow); end
        checks++; if (n_wwe != 0 || n_conv != 0) begin errors++; $display("FAIL bad_activity: wwe=%0d conv=%0d need 0/0", n_wwe, n_conv); end
        start_run(8, 0, 12, 5);
        checks++; if (err !== 1'b1 || ack !== 1'b1) begin errors++; $display("FAIL bad_tin0: err=%b ack=%b need 1/1", err, ack); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_req_ignored();
        start_run(8, 1, 12, 5);
        wait_conv(1000);
        @(negedge clk);
        total_out = CHW'(3);
        img_size  = ISW'(4);
        fil_size  = FSW'(2);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_idle(2000);
        checks++; if (n_wwe != 200 || n_conv != 144 || n_owe != 64) begin
            errors++; $display("FAIL midreq_counts: wwe=%0d conv=%0d owe=%0d need 200/144/64", n_wwe, n_conv, n_owe); end
        checks++; if (out_addr !== 16'd64 || n_err != 0) begin errors++; $display("FAIL midreq_oaddr: got %0d err=%0d need 64/0", out_addr, n_err); end
        repeat (3) @(negedge clk);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL midreq_relaunch: ack=%b need 1", ack); end
    endtask

    task automatic test_reset_mid_run();
        start_run(8, 1, 12, 5);
        wait_conv(1000);
        repeat (5) @(negedge clk);
        xrst = 1'b0;
        @(negedge clk);
        xrst = 1'b1;
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL midrst_ack: got %b need 1", ack); end
        checks++; if ({err, out_nch, w_we, w_core, w_addr, conv_en, in_addr, acc_clr, win_valid, out_we, out_addr} !== '0) begin
            errors++; $display("FAIL midrst_outs: conv=%b in=%0d w=%0d out=%0d nch=%0d need all 0", conv_en, in_addr, w_addr, out_addr, out_nch); end
        repeat (4) @(negedge clk);
        checks++; if (ack !== 1'b1 || conv_en !== 1'b0) begin errors++; $display("FAIL midrst_noresume: ack=%b conv=%b need 1/0", ack, conv_en); end
        start_run(8, 1, 12, 5);
        wait_idle(2000);
        checks++; if (first_w != 0 || first_in != 0 || first_out != 0) begin
            errors++; $display("FAIL midrst_start_addr: w=%0d in=%0d out=%0d need 0/0/0", first_w, first_in, first_out); end
        checks++; if (n_wwe != 200 || n_conv != 144 || n_owe != 64 || out_addr !== 16'd64) begin
            errors++; $display("FAIL midrst_rerun: wwe=%0d conv=%0d owe=%0d oaddr=%0d need 200/144/64/64", n_wwe, n_conv, n_owe, out_addr); end
    endtask

`ifdef RENKON_BIAS_EN
    task automatic test_bias();
        start_run(10, 1, 4, 2);
        wait_idle(2000);
        checks++; if (n_bwe != 10) begin errors++; $display("FAIL bias_bwe: got %0d need 10", n_bwe); end
        checks++; if (b_addr !== 16'd10) begin errors++; $display("FAIL bias_baddr: got %0d need 10", b_addr); end
        checks++; if (n_wwe != 40) begin errors++; $display("FAIL bias_wwe: got %0d need 40", n_wwe); end
    endtask
`endif

    initial begin
        clear_mon();
        test_reset();
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
        test_single_group();
        $display("test_single_group done: checks=%0d errors=%0d", checks, errors);
        test_two_groups();
        $display("test_two_groups done: checks=%0d errors=%0d", checks, errors);
        test_bad_cfg();
        $display("test_bad_cfg done: checks=%0d errors=%0d", checks, errors);
        test_req_ignored();
        $display("test_req_ignored done: checks=%0d errors=%0d", checks, errors);
        test_reset_mid_run();
        $display("test_reset_mid_run done: checks=%0d errors=%0d", checks, errors);
`ifdef RENKON_BIAS_EN
        test_bias();
        $display("test_bias done: checks=%0d errors=%0d", checks, errors);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
